// File: rtl/rr_path_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_path_arbiter
//  Description : Round-robin arbiter that gives one requester at a time the
//                shared single-bit data path, with a bounded hold time.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_path_arbiter #(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] din,
    output logic [NREQ-1:0] gnt,
    output logic            data_out,
    output logic            busy,
    output logic            ovr
);

    localparam int               c_PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] c_HOLD_MAX = CNT_W'(MAX_HOLD);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_GRANT   = 2'd1;
    localparam logic [1:0] c_RECOVER = 2'd2;

    logic [1:0]         r_state;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] r_gidx;
    logic [CNT_W-1:0]   r_cnt;
    logic [NREQ-1:0]    r_gnt;
    logic               r_data;
    logic               r_busy;
    logic               r_ovr;

    logic [1:0]         w_state_nxt;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic [c_PTR_W-1:0] w_gidx_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [NREQ-1:0]    w_gnt_nxt;
    logic               w_data_nxt;
    logic               w_busy_nxt;
    logic               w_ovr_nxt;

    logic [c_PTR_W-1:0] w_win_idx;
    logic [NREQ-1:0]    w_win_onehot;
    logic               w_any_req;
    logic               w_others;
    logic               w_own_req;
    logic               w_timeout;
    logic [c_PTR_W-1:0] w_ptr_inc;

    // Scan from the highest index down so the last hit is the first requester
    // at or after r_ptr in circular order.
    always_comb begin
        logic [c_PTR_W:0] v_sum;
        w_win_idx = r_ptr;
        v_sum     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_sum = {1'b0, r_ptr} + (c_PTR_W + 1)'(k);
            if (v_sum >= (c_PTR_W + 1)'(NREQ)) begin
                v_sum = v_sum - (c_PTR_W + 1)'(NREQ);
            end
            if (req[v_sum[c_PTR_W-1:0]]) begin
                w_win_idx = v_sum[c_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_win_onehot            = '0;
        w_win_onehot[w_win_idx] = 1'b1;
    end

    assign w_any_req = |req;
    assign w_others  = |(req & ~r_gnt);
    assign w_own_req = req[r_gidx];
    assign w_timeout = (r_cnt == c_HOLD_MAX) && w_others;
    assign w_ptr_inc = (r_gidx == c_PTR_W'(NREQ - 1)) ? '0 : r_gidx + c_PTR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_data  <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gidx  <= w_gidx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
            r_ovr   <= w_ovr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gidx_nxt  = r_gidx;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_data_nxt  = r_data;
        w_ovr_nxt   = 1'b0;

        case (r_state)
            c_IDLE, c_RECOVER: begin
                w_gnt_nxt  = '0;
                w_data_nxt = 1'b0;
                if (w_any_req) begin
                    w_state_nxt = c_GRANT;
                    w_gidx_nxt  = w_win_idx;
                    w_gnt_nxt   = w_win_onehot;
                    w_cnt_nxt   = CNT_W'(1);
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            c_GRANT: begin
                w_data_nxt = din[r_gidx];
                // A voluntary release wins over a coincident timeout, so ovr
                // only flags grants that were actually taken away.
                if (!w_own_req || w_timeout) begin
                    w_state_nxt = c_RECOVER;
                    w_gnt_nxt   = '0;
                    w_data_nxt  = 1'b0;
                    w_ptr_nxt   = w_ptr_inc;
                    w_ovr_nxt   = w_own_req;
                end else if (r_cnt != c_HOLD_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_gnt_nxt   = '0;
                w_data_nxt  = 1'b0;
            end
        endcase

        w_busy_nxt = (w_state_nxt != c_IDLE);
    end

    assign gnt      = r_gnt;
    assign data_out = r_data;
    assign busy     = r_busy;
    assign ovr      = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_rr_path_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_path_arbiter
//  Description : Directed self-checking bench for rr_path_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_path_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic [3:0] gnt;
    logic       data_out;
    logic       busy;
    logic       ovr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_path_arbiter #(
        .NREQ     (4),
        .MAX_HOLD (8),
        .CNT_W    (8)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .din      (din),
        .gnt      (gnt),
        .data_out (data_out),
        .busy     (busy),
        .ovr      (ovr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] g, input logic d,
                             input logic b, input logic o);
        check({tag, ".gnt"},  32'(gnt),      32'(g));
        check({tag, ".data"}, 32'(data_out), 32'(d));
        check({tag, ".busy"}, 32'(busy),     32'(b));
        check({tag, ".ovr"},  32'(ovr),      32'(o));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [3:0] c_ROT_SEQ [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] v_owner;
        rst = 1'b1;
        req = 4'b0000;
        din = 4'b0000;
        step();
        step();
        check_out("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        check_out("idle", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Single requester, data follows din[0] with one cycle of lag
        req = 4'b0001;
        din = 4'b0001;
        step();
        check_out("single.grant", 4'b0001, 1'b0, 1'b1, 1'b0);
        step();
        check("single.d1", 32'(data_out), 32'd1);
        din = 4'b0000;
        step();
        check("single.d0", 32'(data_out), 32'd0);
        din = 4'b0001;
        step();
        check("single.d1b", 32'(data_out), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("single.hold.gnt", 32'(gnt), 32'h1);
            check("single.hold.ovr", 32'(ovr), 32'h0);
        end
        req = 4'b0000;
        step();
        check_out("single.recover", 4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        check_out("single.idle", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        check_out("single.idle2", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Rotation from ptr 0 with all four requesting
        rst = 1'b1;
        #1;
        rst = 1'b0;
        req = 4'b1111;
        din = 4'b0000;
        step();
        for (int i = 0; i < 4; i++) begin
            v_owner = c_ROT_SEQ[i];
            check("rot.grant", 32'(gnt), 32'(v_owner));
            step();
            check("rot.hold", 32'(gnt), 32'(v_owner));
            req = req & ~v_owner;
            step();
            check("rot.bubble.gnt", 32'(gnt), 32'h0);
            check("rot.bubble.busy", 32'(busy), 32'h1);
            req = 4'b1111;
            step();
        end
        check("rot.wrap", 32'(gnt), 32'h1);
        req = 4'b0000;
        step();
        step();
        check("rot.idle.busy", 32'(busy), 32'h0);

        // Hold timeout: req[2] arrives during the third grant cycle
        req = 4'b0001;
        step();
        check("to.grant", 32'(gnt), 32'h1);
        step();
        step();
        req = 4'b0101;
        for (int i = 4; i <= 8; i++) begin
            step();
            check("to.hold.gnt", 32'(gnt), 32'h1);
            check("to.hold.ovr", 32'(ovr), 32'h0);
        end
        step();
        check_out("to.revoke", 4'b0000, 1'b0, 1'b1, 1'b1);
        step();
        check_out("to.next", 4'b0100, 1'b0, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        step();
        check("to.idle.busy", 32'(busy), 32'h0);

        // Release on the same cycle the hold limit is reached
        req = 4'b0001;
        step();
        check("col.grant", 32'(gnt), 32'h1);
        req = 4'b0011;
        for (int i = 2; i <= 8; i++) begin
            step();
            check("col.hold", 32'(gnt), 32'h1);
        end
        req = 4'b0010;
        step();
        check_out("col.release", 4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        check_out("col.next", 4'b0010, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a grant, between clock edges
        #2;
        rst = 1'b1;
        #1;
        check_out("async.rst", 4'b0000, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        req = 4'b0000;
        step();
        check_out("async.idle", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Pointer wrap and isolation of non-granted din bits
        req = 4'b0100;
        din = 4'b1011;
        step();
        check_out("wrap.g2", 4'b0100, 1'b0, 1'b1, 1'b0);
        step();
        check("wrap.g2.data", 32'(data_out), 32'h0);
        req = 4'b1001;
        step();
        check_out("wrap.bubble", 4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        check_out("wrap.g3", 4'b1000, 1'b0, 1'b1, 1'b0);
        din = 4'b0111;
        step();
        check("wrap.g3.data0", 32'(data_out), 32'h0);
        din = 4'b1000;
        step();
        check("wrap.g3.data1", 32'(data_out), 32'h1);
        req = 4'b0001;
        step();
        check_out("wrap.bubble2", 4'b0000, 1'b0, 1'b1, 1'b0);
        step();
        check("wrap.g0", 32'(gnt), 32'h1);
        din = 4'b1110;
        step();
        check("wrap.g0.data0", 32'(data_out), 32'h0);
        din = 4'b0001;
        step();
        check("wrap.g0.data1", 32'(data_out), 32'h1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_path_arbiter.md
Name: rr_path_arbiter

Overview:
- Round-robin arbiter/sequencer sharing one single-bit buffered data path (the `data_out` leg) among NREQ requesters.
- Grants one requester at a time and routes its `din` bit to a registered `data_out`.
- Enforces a maximum hold time so no requester can starve the others.
- Sits in front of the shared buffer path as its only driver.
- Whole block is a triplication target, so all state is in plain registers with no initial values.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- MAX_HOLD, 8, cycles a grant may be held while another requester waits; legal range 1..255.
- CNT_W, 8, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  request per requester; level, held while access is wanted.
- din  input  NREQ  data bit per requester; only the granted bit is used.
- gnt  output  NREQ  one-hot grant, registered; all zeros when nobody is granted.
- data_out  output  1  registered copy of `din[granted]`; 0 when nobody is granted.
- busy  output  1  high whenever the FSM is not in IDLE.
- ovr  output  1  one-cycle pulse when a grant is revoked by hold timeout.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-grant):
  - state = IDLE, ptr = 0, cnt = 0.
  - gnt = 0, data_out = 0, busy = 0, ovr = 0.
- ptr: index of the highest-priority requester. Winner = first `req[i]` set, scanning i = ptr, ptr+1, ... mod NREQ.
- IDLE:
  - If any `req` is set: next edge loads gnt = onehot(winner), cnt = 1, state = GRANT.
  - Latency from req rising to gnt is 1 cycle. Otherwise stay in IDLE.
- GRANT (g = granted index):
  - Every cycle: data_out <= din[g], giving 1-cycle latency from din to data_out.
  - Release: if req[g] = 0, then state = RECOVER, gnt = 0, data_out = 0, ptr = (g+1) mod NREQ.
  - Timeout: else if cnt == MAX_HOLD and any other req is set, take the release actions above and pulse ovr = 1 for exactly one cycle.
  - Saturate: else if cnt == MAX_HOLD and no other req is set, cnt holds at MAX_HOLD and the grant continues.
  - Otherwise cnt = cnt + 1.
- RECOVER:
  - Exactly one cycle with gnt = 0 and data_out = 0, which guarantees a bubble between owners.
  - Then arbitrate with the updated ptr: if any req is set, grant the winner (cnt = 1, GRANT); else go to IDLE.
  - The previous owner may win again only if no other requester is active.
- busy = (state != IDLE). busy is registered and stays high through RECOVER.
- Simultaneous release and timeout in the same cycle: treated as a release, ovr stays 0.
- `req` bits of non-granted requesters may toggle freely and have no effect until the next arbitration.
- `din` bits of non-granted requesters never reach data_out.
- gnt is never multi-hot; gnt is never nonzero during IDLE or RECOVER.
- Arithmetic: cnt is unsigned CNT_W-bit and never wraps. ptr increments mod NREQ (NREQ-1 wraps to 0).

Test Plan:
- Reset/idle: assert rst mid-run with gnt = 0010 -> gnt, data_out, busy, ovr read 0 in the same cycle without waiting for a clk edge. After release, req = 0 -> all outputs stay 0.
- Single requester: req = 0001, din[0] toggling 1,0,1 -> gnt = 0001 one cycle after req; data_out follows din[0] with 1-cycle lag. With no competitor, the grant holds beyond 8 cycles and ovr = 0.
- Rotation: req = 1111 held, each owner drops its req after 2 cycles -> grant order 0,1,2,3,0. Exactly one gnt = 0 bubble between consecutive grants.
- Timeout: MAX_HOLD = 8, req[0] held, req[2] rises at cycle 3 of the grant -> gnt[0] drops after cnt reaches 8, ovr = 1 for one cycle, RECOVER, then gnt = 0100.
- Release/timeout collision: req[0] drops on the same cycle cnt == 8 while req[1] = 1 -> ovr stays 0 and gnt = 0010 after one bubble.
- Wrap/priority: ptr = 3 (last owner 2), req = 1001 -> requester 3 is granted first, then 0. Verify data_out never reflects a non-granted din bit.
